cpu_clock_ctrl: RTL and testbench

Run/step/halt sequencer for the CPU clock enable, built on the same CLKI-domain counter scheme as the board clock divider. It turns the run switch, the step button, the rate select and the CPU halt flag into a single-cycle enable pulse, CPU_EN, that gates every CPU register. There is no derived clock. It sits between the board I/O and the CPU top, and replaces direct use of a divided clock for CPU stepping.

---
 rtl/cpu_clk_ctrl_pkg.sv | 21 ++
 rtl/btn_debounce.sv | 58 +++++
 rtl/cpu_clock_ctrl.sv | 133 +++++++++++++
 tb/tb_cpu_clock_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared encodings for the CPU run/step/halt clock-enable sequencer.
// STATE drives the board LEDs directly, so these encodings are fixed.
package cpu_clk_ctrl_pkg;

    typedef enum logic [1:0] {
        S_PAUSE = 2'd0,
        S_RUN   = 2'd1,
        S_STEP  = 2'd2,
        S_HALT  = 2'd3
    } cpu_state_e;

    typedef enum logic [1:0] {
        RATE_DIV0 = 2'd0,
        RATE_DIV1 = 2'd1,
        RATE_DIV2 = 2'd2,
        RATE_FULL = 2'd3
    } rate_e;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/btn_debounce.sv
// Synchronizes a bouncy push button, debounces it with a stable-cycle counter
// and emits a one-cycle pulse on each rising edge of the debounced level.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic CLKI,
    input  logic RST,
    input  logic btn,
    output logic rise
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            meta_q;
    logic            sync_q;
    logic [DB_W-1:0] stable_cnt_q;
    logic            level_q;
    logic            level_d1_q;

    always_ff @(posedge CLKI or negedge RST) begin
        if (!RST) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn;
            sync_q <= meta_q;
        end
    end

    // Any cycle where the input agrees with the level restarts the count.
    always_ff @(posedge CLKI or negedge RST) begin
        if (!RST) begin
            stable_cnt_q <= '0;
            level_q      <= 1'b0;
        end else if (sync_q != level_q) begin
            if (stable_cnt_q == DB_LAST) begin
                stable_cnt_q <= '0;
                level_q      <= sync_q;
            end else begin
                stable_cnt_q <= stable_cnt_q + DB_W'(1);
            end
        end else begin
            stable_cnt_q <= '0;
        end
    end

    always_ff @(posedge CLKI or negedge RST) begin
        if (!RST) begin
            level_d1_q <= 1'b0;
        end else begin
            level_d1_q <= level_q;
        end
    end

    assign rise = level_q & ~level_d1_q;

endmodule

// File: rtl/cpu_clock_ctrl.sv
// Run/step/halt sequencer producing the single-cycle CPU_EN pulse that gates
// every CPU register; no derived clock, everything runs on CLKI.
module cpu_clock_ctrl
    import cpu_clk_ctrl_pkg::*;
#(
    parameter int DIV0            = 99_999_999,
    parameter int DIV1            = 9_999_999,
    parameter int DIV2            = 999_999,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 27
) (
    input  logic       CLKI,
    input  logic       RST,
    input  logic       MODE_RUN,
    input  logic       STEP_BTN,
    input  logic [1:0] RATE_SEL,
    input  logic       HALT,
    output logic       CPU_EN,
    output logic [1:0] STATE,
    output logic       TICK_LED
);

    logic [SYNC_STAGES-1:0] mode_sync_q;
    logic [1:0]             rate_meta_q;
    logic [1:0]             rate_sync_q;
    logic                   mode_s;
    rate_e                  rate_s;
    logic                   step_evt;

    cpu_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       term;
    logic                   en_q, en_d;
    logic                   tick_q, tick_d;

    // Slide switch and rate select are slow levels; a plain 2-FF chain suffices.
    always_ff @(posedge CLKI or negedge RST) begin
        if (!RST) begin
            mode_sync_q <= '0;
            rate_meta_q <= '0;
            rate_sync_q <= '0;
        end else begin
            mode_sync_q <= {mode_sync_q[SYNC_STAGES-2:0], MODE_RUN};
            rate_meta_q <= RATE_SEL;
            rate_sync_q <= rate_meta_q;
        end
    end

    assign mode_s = mode_sync_q[SYNC_STAGES-1];
    assign rate_s = rate_e'(rate_sync_q);

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_step_db (
        .CLKI (CLKI),
        .RST  (RST),
        .btn  (STEP_BTN),
        .rise (step_evt)
    );

    // Full rate uses a terminal count of zero so the >= compare fires every cycle.
    always_comb begin
        term = '0;
        case (rate_s)
            RATE_DIV0: term = CNT_W'(DIV0);
            RATE_DIV1: term = CNT_W'(DIV1);
            RATE_DIV2: term = CNT_W'(DIV2);
            RATE_FULL: term = '0;
            default:   term = '0;
        endcase
    end

    always_ff @(posedge CLKI or negedge RST) begin
        if (!RST) begin
            state_q <= S_PAUSE;
            cnt_q   <= '0;
            en_q    <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            tick_q  <= tick_d;
        end
    end

    // en_d is the value CPU_EN takes next cycle, so the enable stays registered.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        en_d    = 1'b0;
        case (state_q)
            S_PAUSE: begin
                if (HALT) begin
                    state_d = S_HALT;
                end else if (mode_s) begin
                    state_d = S_RUN;
                end else if (step_evt) begin
                    state_d = S_STEP;
                    en_d    = 1'b1;
                end
            end
            S_STEP: begin
                state_d = S_PAUSE;
            end
            S_RUN: begin
                if (HALT) begin
                    state_d = S_HALT;
                end else if (!mode_s) begin
                    state_d = S_PAUSE;
                end else if (cnt_q >= term) begin
                    en_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HALT: begin
                if (!HALT) begin
                    state_d = S_PAUSE;
                end
            end
            default: begin
                state_d = S_PAUSE;
            end
        endcase
        tick_d = tick_q ^ en_d;
    end

    assign CPU_EN   = en_q;
    assign STATE    = state_q;
    assign TICK_LED = tick_q;

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with small divider and debounce values.
module tb_cpu_clock_ctrl;

    logic       CLKI;
    logic       RST;
    logic       MODE_RUN;
    logic       STEP_BTN;
    logic [1:0] RATE_SEL;
    logic       HALT;
    logic       CPU_EN;
    logic [1:0] STATE;
    logic       TICK_LED;

    int n_cmp;
    int n_fail;
    int pulse_cnt;
    int n;

    cpu_clock_ctrl #(
        .DIV0            (9),
        .DIV1            (4),
        .DIV2            (1),
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (27)
    ) dut (
        .CLKI     (CLKI),
        .RST      (RST),
        .MODE_RUN (MODE_RUN),
        .STEP_BTN (STEP_BTN),
        .RATE_SEL (RATE_SEL),
        .HALT     (HALT),
        .CPU_EN   (CPU_EN),
        .STATE    (STATE),
        .TICK_LED (TICK_LED)
    );

    // clock / reset
    initial begin
        CLKI = 1'b0;
        forever #5 CLKI = ~CLKI;
    end

    // driver tasks
    task automatic step();
        @(posedge CLKI);
        #1;
        if (CPU_EN === 1'b1) pulse_cnt++;
    endtask

    task automatic step_n(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic count_pulses(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (CPU_EN === 1'b1) cnt++;
        end
    endtask

    task automatic wait_en(input int max_cycles, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cycles && cyc < 0; i++) begin
            step();
            if (CPU_EN === 1'b1) cyc = i;
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int max_cycles, output int cyc);
        cyc = -1;
        for (int i = 1; i <= max_cycles && cyc < 0; i++) begin
            step();
            if (STATE === s) cyc = i;
        end
    endtask

    // scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        pulse_cnt = 0;
        RST       = 1'b1;
        MODE_RUN  = 1'b0;
        STEP_BTN  = 1'b0;
        RATE_SEL  = 2'd0;
        HALT      = 1'b0;
        #2 RST = 1'b0;

        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_cpu_en", CPU_EN, 0);
            check("rst_state", STATE, 0);
            check("rst_tick", TICK_LED, 0);
        end
        pulse_cnt = 0;

        // run at RATE_SEL=0: entry 3 cycles after the switch, then period 10
        RST      = 1'b1;
        MODE_RUN = 1'b1;
        RATE_SEL = 2'd0;
        wait_state(2'd1, 10, n);
        check("run_entry_lat", n, 3);
        wait_en(20, n);
        check("run_first_pulse", n, 10);
        check("run_tick1", TICK_LED, 1);
        wait_en(20, n);
        check("run_period", n, 10);
        check("run_tick2", TICK_LED, 0);
        step();
        check("run_pulse_width", CPU_EN, 0);

        // rate change at counter=7: drop to DIV1 fires after sync delay, then every 5
        step_n(6);
        RATE_SEL = 2'd1;
        wait_en(20, n);
        check("rate_drop_first", n, 3);
        wait_en(20, n);
        check("rate_div1_period_a", n, 5);
        wait_en(20, n);
        check("rate_div1_period_b", n, 5);
        RATE_SEL = 2'd3;
        wait_en(20, n);
        check("rate_full_first", n, 3);
        count_pulses(8, n);
        check("rate_full_continuous", n, 8);
        check("rate_full_tick", TICK_LED, pulse_cnt[0]);

        // HALT: no pulse from the next cycle on, step presses dropped
        HALT = 1'b1;
        step();
        check("halt_state", STATE, 3);
        check("halt_no_en", CPU_EN, 0);
        MODE_RUN = 1'b0;
        RATE_SEL = 2'd0;
        count_pulses(10, n);
        check("halt_quiet", n, 0);
        STEP_BTN = 1'b1;
        count_pulses(10, n);
        check("halt_step_ignored", n, 0);
        check("halt_state_hold", STATE, 3);
        STEP_BTN = 1'b0;
        count_pulses(10, n);
        check("halt_release_quiet", n, 0);
        HALT = 1'b0;
        step();
        check("unhalt_state", STATE, 0);
        count_pulses(5, n);
        check("unhalt_quiet", n, 0);
        check("unhalt_state_hold", STATE, 0);
        check("halt_tick", TICK_LED, pulse_cnt[0]);

        // bouncy step press: 1-0-1 at 2-cycle spacing, then held
        STEP_BTN = 1'b1;
        step_n(2);
        STEP_BTN = 1'b0;
        step_n(2);
        STEP_BTN = 1'b1;
        wait_en(20, n);
        check("step_latency", n, 7);
        check("step_state", STATE, 2);
        step();
        check("step_width", CPU_EN, 0);
        check("step_back_pause", STATE, 0);
        count_pulses(10, n);
        check("step_held_once", n, 0);
        STEP_BTN = 1'b0;
        step_n(2);
        STEP_BTN = 1'b1;
        count_pulses(10, n);
        check("step_glitch_ignored", n, 0);
        STEP_BTN = 1'b0;
        count_pulses(10, n);
        check("step_release_quiet", n, 0);
        STEP_BTN = 1'b1;
        wait_en(20, n);
        check("step2_latency", n, 7);
        STEP_BTN = 1'b0;
        count_pulses(10, n);
        check("step2_single", n, 0);
        check("step_tick", TICK_LED, pulse_cnt[0]);

        // pause mid-count at counter=3, then re-enter run
        MODE_RUN = 1'b1;
        wait_state(2'd1, 10, n);
        check("pause_run_entry", n, 3);
        step();
        MODE_RUN = 1'b0;
        count_pulses(12, n);
        check("pause_no_pulse", n, 0);
        check("pause_state", STATE, 0);
        MODE_RUN = 1'b1;
        wait_state(2'd1, 10, n);
        check("rerun_entry", n, 3);
        wait_en(20, n);
        check("rerun_first_pulse", n, 10);

        // reset during a partially debounced press
        MODE_RUN = 1'b0;
        step_n(8);
        check("pre_rst_state", STATE, 0);
        STEP_BTN = 1'b1;
        step_n(4);
        RST       = 1'b0;
        STEP_BTN  = 1'b0;
        pulse_cnt = 0;
        step();
        check("midrst_state", STATE, 0);
        check("midrst_cpu_en", CPU_EN, 0);
        check("midrst_tick", TICK_LED, 0);
        step();
        RST = 1'b1;
        count_pulses(15, n);
        check("midrst_no_step", n, 0);
        check("midrst_state_after", STATE, 0);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
